// File: rtl/mem_arb_pkg.sv
// Shared encodings and types for the memory request arbiter.
// Agent indices are sized for the largest supported agent count.
package mem_arb_pkg;

  localparam logic        MEM_WRITE  = 1'b1;
  localparam logic        MEM_READ   = 1'b0;
  localparam int unsigned MAX_AGENTS = 8;

  typedef logic [$clog2(MAX_AGENTS)-1:0] agent_idx_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic agent_idx_t next_ptr(input agent_idx_t g, input int unsigned n);
    agent_idx_t r;
    if ((int'(g) + 32'sd1) >= int'(n)) begin
      r = '0;
    end else begin
      r = g + agent_idx_t'(1'b1);
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_sva.sv
// Protocol checker: an agent holding a locked grant must keep its request raised.
module mem_req_arbiter_sva (
  input logic clk_i,
  input logic rst_i,
  input logic locked_i,
  input logic held_valid_i
);

  a_hold_valid: assert property (@(posedge clk_i) disable iff (rst_i) locked_i |-> held_valid_i)
    else $error("mem_req_arbiter: granted agent dropped valid while locked");

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr_i, circularly.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req_i,
  input  agent_idx_t   ptr_i,
  output agent_idx_t   grant_o,
  output logic         any_req_o
);

  logic [2*N-1:0] req2_s;
  logic [N-1:0]   rot_s;
  logic [N-1:0]   scan_s;
  int             pos_s;

  assign req2_s = {req_i, req_i};
  assign rot_s  = N'(req2_s >> ptr_i);

  // Walk the rotated request vector from bit 0; the first hit is the winner.
  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    scan_s    = rot_s;
    pos_s     = 0;
    for (int i = 0; i < int'(N); i++) begin
      pos_s     = int'(ptr_i) + i;
      pos_s     = (pos_s >= int'(N)) ? (pos_s - int'(N)) : pos_s;
      grant_o   = (scan_s[0] && !any_req_o) ? agent_idx_t'(pos_s) : grant_o;
      any_req_o = any_req_o | scan_s[0];
      scan_s    = scan_s >> 1;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin N-agent arbiter in front of a single-port memory, with read-data
// return routing and an accepted-transaction counter.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_AGENTS = 2,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_AGENTS-1:0]            a_valid_i,
  output logic [NUM_AGENTS-1:0]            a_ready_o,
  input  logic [NUM_AGENTS*ADDR_WIDTH-1:0] a_addr_i,
  input  logic [NUM_AGENTS-1:0]            a_wr_rd_i,
  input  logic [NUM_AGENTS*DATA_WIDTH-1:0] a_wr_data_i,
  output logic [DATA_WIDTH-1:0]            a_rd_data_o,
  output logic [NUM_AGENTS-1:0]            a_rd_valid_o,
  output logic                             m_valid_o,
  input  logic                             m_ready_i,
  output logic [ADDR_WIDTH-1:0]            m_addr_o,
  output logic                             m_wr_rd_o,
  output logic [DATA_WIDTH-1:0]            m_wr_data_o,
  input  logic [DATA_WIDTH-1:0]            m_rd_data_i,
  output logic [31:0]                      txn_count_o
);

  localparam int unsigned IW = $bits(agent_idx_t);

  arb_state_e                   state_q;
  agent_idx_t                   grant_q;
  agent_idx_t                   rr_ptr_q;
  agent_idx_t                   rr_ptr_d;
  agent_idx_t                   pick_grant_s;
  agent_idx_t                   sel_s;
  logic                         pick_any_s;
  logic                         handshake_s;
  logic                         held_valid_s;
  logic                         rd_push_s;
  logic [31:0]                  txn_count_q;
  logic [RD_LATENCY-1:0]        tag_vld_q;
  logic [RD_LATENCY*IW-1:0]     tag_idx_q;
  agent_idx_t                   tag_out_s;
  logic [NUM_AGENTS-1:0]        rd_valid_q;
  logic [NUM_AGENTS-1:0]        rd_valid_d;
  logic [DATA_WIDTH-1:0]        rd_data_q;

  rr_pick #(
    .N(NUM_AGENTS)
  ) u_rr_pick (
    .req_i    (a_valid_i),
    .ptr_i    (rr_ptr_q),
    .grant_o  (pick_grant_s),
    .any_req_o(pick_any_s)
  );

  // Choose the driving agent (held grant while locked) and steer its payload to memory.
  always_comb begin
    sel_s = (state_q == ARB_LOCKED) ? grant_q : pick_grant_s;
    if (rst) begin
      m_valid_o = 1'b0;
    end else if (state_q == ARB_LOCKED) begin
      m_valid_o = 1'b1;
    end else begin
      m_valid_o = pick_any_s;
    end
    m_addr_o     = ADDR_WIDTH'(a_addr_i >> (32'(sel_s) * ADDR_WIDTH));
    m_wr_rd_o    = 1'(a_wr_rd_i >> sel_s);
    m_wr_data_o  = DATA_WIDTH'(a_wr_data_i >> (32'(sel_s) * DATA_WIDTH));
    handshake_s  = m_valid_o && m_ready_i;
    a_ready_o    = handshake_s ? (NUM_AGENTS'(1'b1) << sel_s) : '0;
    rd_push_s    = handshake_s && (m_wr_rd_o == MEM_READ);
    held_valid_s = |(a_valid_i & (NUM_AGENTS'(1'b1) << grant_q));
    rr_ptr_d     = next_ptr(sel_s, NUM_AGENTS);
    tag_out_s    = tag_idx_q[(RD_LATENCY-1)*IW +: IW];
    rd_valid_d   = tag_vld_q[RD_LATENCY-1] ? (NUM_AGENTS'(1'b1) << tag_out_s) : '0;
  end

  // Arbitration FSM, pointer/counter update and the registered read-return path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      txn_count_q <= 32'd0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any_s && !m_ready_i) begin
            state_q <= ARB_LOCKED;
            grant_q <= pick_grant_s;
          end else begin
            state_q <= ARB_IDLE;
          end
        end
        ARB_LOCKED: begin
          if (m_ready_i) begin
            state_q <= ARB_IDLE;
          end else begin
            state_q <= ARB_LOCKED;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase

      if (handshake_s) begin
        rr_ptr_q    <= rr_ptr_d;
        txn_count_q <= txn_count_q + 32'd1;
      end

      // Writes still shift a slot through, just with the valid bit clear.
      tag_vld_q <= (tag_vld_q << 1) | RD_LATENCY'(rd_push_s);
      tag_idx_q <= (tag_idx_q << IW) | (RD_LATENCY*IW)'(sel_s);

      rd_valid_q <= rd_valid_d;
      if (tag_vld_q[RD_LATENCY-1]) begin
        rd_data_q <= m_rd_data_i;
      end
    end
  end

  assign a_rd_valid_o = rd_valid_q;
  assign a_rd_data_o  = rd_data_q;
  assign txn_count_o  = txn_count_q;

  mem_req_arbiter_sva u_sva (
    .clk_i       (clk),
    .rst_i       (rst),
    .locked_i    (state_q == ARB_LOCKED),
    .held_valid_i(held_valid_s)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a small memory model answers the memory port,
// and expected read returns are queued at issue and checked when they come back.
module tb_mem_req_arbiter;

  localparam int NA = 2;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int RL = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NA-1:0]     a_valid_i, a_ready_o, a_wr_rd_i, a_rd_valid_o;
  logic [NA*AW-1:0]  a_addr_i;
  logic [NA*DW-1:0]  a_wr_data_i;
  logic [DW-1:0]     a_rd_data_o;
  logic              m_valid_o, m_ready_i, m_wr_rd_o;
  logic [AW-1:0]     m_addr_o;
  logic [DW-1:0]     m_wr_data_o, m_rd_data_i;
  logic [31:0]       txn_count_o;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int exp_ptr;
  int g;

  typedef struct {
    logic [NA-1:0] oh;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  rd_exp_t       sb[$];
  rd_exp_t       e;
  logic [DW-1:0] mem_q [16];
  logic [DW-1:0] shadow [16];
  logic [DW-1:0] mem_rd_q = '0;

  mem_req_arbiter #(
    .NUM_AGENTS(NA), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_addr_i(a_addr_i),
    .a_wr_rd_i(a_wr_rd_i), .a_wr_data_i(a_wr_data_i), .a_rd_data_o(a_rd_data_o),
    .a_rd_valid_o(a_rd_valid_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_addr_o(m_addr_o), .m_wr_rd_o(m_wr_rd_o), .m_wr_data_o(m_wr_data_o),
    .m_rd_data_i(m_rd_data_i), .txn_count_o(txn_count_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memory with one cycle of read latency.
  assign m_rd_data_i = mem_rd_q;
  always @(posedge clk) begin
    if (m_valid_o && m_ready_i) begin
      if (m_wr_rd_o) mem_q[m_addr_o] <= m_wr_data_o;
      else mem_rd_q <= mem_q[m_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    a_valid_i[k] = v;
    a_wr_rd_i[k] = wr;
    a_addr_i[k*AW +: AW] = addr;
    a_wr_data_i[k*DW +: DW] = data;
    if (v && wr) shadow[addr] = data;
  endtask

  // Called in the cycle whose rising edge accepts the read.
  task automatic expect_read(input int k, input logic [AW-1:0] addr);
    rd_exp_t x;
    x.oh = NA'(1) << k;
    x.data = shadow[addr];
    x.due = cyc + 1 + RL;
    sb.push_back(x);
  endtask

  // Read-return scoreboard.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      check("rd_missing", 32'(cyc), 32'(sb[0].due));
      void'(sb.pop_front());
    end
    if (a_rd_valid_o !== '0) begin
      if (sb.size() == 0) begin
        check("rd_unexpected", 32'(a_rd_valid_o), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rd_owner", 32'(a_rd_valid_o), 32'(e.oh));
        check("rd_data", 32'(a_rd_data_o), 32'(e.data));
        check("rd_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    rst = 1'b1; a_valid_i = '0; a_wr_rd_i = '0; a_addr_i = '0; a_wr_data_i = '0;
    m_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_a_ready", 32'(a_ready_o), 32'd0);
    check("rst_rd_valid", 32'(a_rd_valid_o), 32'd0);
    check("rst_rd_data", 32'(a_rd_data_o), 32'd0);
    check("rst_m_valid", 32'(m_valid_o), 32'd0);
    check("rst_txn", txn_count_o, 32'd0);
    rst = 1'b0;

    // Agent0 writes A5A5 to addr 3 then reads it back.
    @(negedge clk); drive(0, 1'b1, 1'b1, 4'd3, 16'hA5A5); m_ready_i = 1'b1; #1;
    check("t1_m_valid", 32'(m_valid_o), 32'd1);
    check("t1_m_addr", 32'(m_addr_o), 32'd3);
    check("t1_m_wr_rd", 32'(m_wr_rd_o), 32'd1);
    check("t1_m_wr_data", 32'(m_wr_data_o), 32'hA5A5);
    check("t1_wr_ready", 32'(a_ready_o), 32'd1);
    @(negedge clk); drive(0, 1'b1, 1'b0, 4'd3, 16'h0000); #1;
    check("t1_rd_ready", 32'(a_ready_o), 32'd1);
    check("t1_rd_wr_rd", 32'(m_wr_rd_o), 32'd0);
    expect_read(0, 4'd3);
    @(negedge clk); drive(0, 1'b0, 1'b0, 4'd0, 16'h0000);
    repeat (2) @(negedge clk);
    #1; check("t1_txn", txn_count_o, 32'd2);

    // Both agents request continuously; grants rotate starting after agent0.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'd4, 16'h1111);
    drive(1, 1'b1, 1'b1, 4'd5, 16'h2222);
    exp_ptr = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      g = exp_ptr;
      check("t2_grant", 32'(a_ready_o), 32'(1 << g));
      check("t2_addr", 32'(m_addr_o), (g == 1) ? 32'd5 : 32'd4);
      exp_ptr = (g + 1) % NA;
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 4'd0, 16'h0000);
    drive(1, 1'b0, 1'b0, 4'd0, 16'h0000);
    #1; check("t2_txn", txn_count_o, 32'd10);

    // Agent1 stalls on memory; agent0 joins late and must wait for the held grant.
    @(negedge clk); drive(1, 1'b1, 1'b1, 4'd6, 16'h3333); m_ready_i = 1'b0; #1;
    check("t3_m_valid", 32'(m_valid_o), 32'd1);
    check("t3_addr_a", 32'(m_addr_o), 32'd6);
    check("t3_no_ready", 32'(a_ready_o), 32'd0);
    @(negedge clk); drive(0, 1'b1, 1'b1, 4'd7, 16'h4444); #1;
    check("t3_addr_b", 32'(m_addr_o), 32'd6);
    check("t3_no_ready_b", 32'(a_ready_o), 32'd0);
    @(negedge clk); #1;
    check("t3_addr_c", 32'(m_addr_o), 32'd6);
    @(negedge clk); m_ready_i = 1'b1; #1;
    check("t3_acc_agent1", 32'(a_ready_o), 32'd2);
    check("t3_addr_d", 32'(m_addr_o), 32'd6);
    @(negedge clk); drive(1, 1'b0, 1'b0, 4'd0, 16'h0000); #1;
    check("t3_acc_agent0", 32'(a_ready_o), 32'd1);
    check("t3_addr_e", 32'(m_addr_o), 32'd7);
    @(negedge clk); drive(0, 1'b0, 1'b0, 4'd0, 16'h0000); #1;
    check("t3_txn", txn_count_o, 32'd12);

    // Back-to-back reads from different agents return on consecutive cycles.
    drive(0, 1'b1, 1'b1, 4'd1, 16'hBEEF); #1;
    check("t4_wr0", 32'(a_ready_o), 32'd1);
    @(negedge clk); drive(0, 1'b0, 1'b0, 4'd0, 16'h0000); drive(1, 1'b1, 1'b1, 4'd2, 16'hCAFE); #1;
    check("t4_wr1", 32'(a_ready_o), 32'd2);
    @(negedge clk); drive(1, 1'b0, 1'b0, 4'd0, 16'h0000); drive(0, 1'b1, 1'b0, 4'd1, 16'h0000); #1;
    check("t4_rd0", 32'(a_ready_o), 32'd1);
    expect_read(0, 4'd1);
    @(negedge clk); drive(0, 1'b0, 1'b0, 4'd0, 16'h0000); drive(1, 1'b1, 1'b0, 4'd2, 16'h0000); #1;
    check("t4_rd1", 32'(a_ready_o), 32'd2);
    expect_read(1, 4'd2);
    @(negedge clk); drive(1, 1'b0, 1'b0, 4'd0, 16'h0000);
    repeat (3) @(negedge clk);
    #1;
    check("t4_sb_empty", 32'(sb.size()), 32'd0);
    check("t4_txn", txn_count_o, 32'd16);

    // Reset lands one cycle after a read handshake: the return must be dropped.
    @(negedge clk); drive(1, 1'b1, 1'b0, 4'd2, 16'h0000); #1;
    check("t5_rd_ready", 32'(a_ready_o), 32'd2);
    @(negedge clk); drive(1, 1'b0, 1'b0, 4'd0, 16'h0000); rst = 1'b1;
    @(negedge clk); #1;
    check("t5_rd_valid", 32'(a_rd_valid_o), 32'd0);
    check("t5_rd_data", 32'(a_rd_data_o), 32'd0);
    check("t5_m_valid", 32'(m_valid_o), 32'd0);
    check("t5_a_ready", 32'(a_ready_o), 32'd0);
    check("t5_txn", txn_count_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'd8, 16'h5555);
    drive(1, 1'b1, 1'b1, 4'd9, 16'h6666);
    #1;
    check("t5_rd_valid_after", 32'(a_rd_valid_o), 32'd0);
    check("t5_first_grant", 32'(a_ready_o), 32'd1);
    @(negedge clk); #1;
    check("t5_second_grant", 32'(a_ready_o), 32'd2);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'd0, 16'h0000);
    drive(1, 1'b0, 1'b0, 4'd0, 16'h0000);
    #1; check("t5_txn_after", txn_count_o, 32'd2);

    // Idle period: no requests, no transfers.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("t6_m_valid", 32'(m_valid_o), 32'd0);
    end
    check("t6_txn", txn_count_o, 32'd2);
    check("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
